// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default width, control-strobe
// bit positions used by both the controller FSM and the datapath.
package div_pkg;

  localparam int DIV_W = 8;

  // Control strobe positions within the c0..c7 bundle
  localparam int C_LD_M    = 0;
  localparam int C_LD_Q    = 1;
  localparam int C_SHIFT   = 2;
  localparam int C_SUB     = 3;
  localparam int C_ADD     = 4;
  localparam int C_SET_Q0  = 5;
  localparam int C_OUT_R   = 6;
  localparam int C_OUT_Q   = 7;
  localparam int N_STROBES = 8;

  // Bits needed to hold values 0..limit inclusive
  function automatic int cnt_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/div_counter.sv
// Saturating iteration counter: sync clear, increment, and a terminal-count
// flag that stays asserted once the limit is reached.
module div_counter
  import div_pkg::*;
#(
  parameter int LIMIT = DIV_W
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic done
);

  localparam int CW = cnt_width(LIMIT);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_limit;

  assign at_limit = (cnt_q == LIMIT_C);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_limit) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = at_limit;

endmodule

// File: rtl/div_datapath.sv
// Restoring-divider datapath: holds divisor M, partial remainder A and
// dividend/quotient Q, executes controller strobes and reports FSM status.
module div_datapath
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] inbus,
  input  logic         c0,
  input  logic         c1,
  input  logic         c2,
  input  logic         c3,
  input  logic         c4,
  input  logic         c5,
  input  logic         c6,
  input  logic         c7,
  output logic [W-1:0] outbus,
  output logic         out_valid,
  output logic         cnt_done,
  output logic         q0,
  output logic         a7
);

  logic [N_STROBES-1:0] ctrl;

  logic [W-1:0] m_q, m_d;
  logic [W-1:0] q_q, q_d;
  logic [W:0]   a_q, a_d;
  logic [W-1:0] outbus_q, outbus_d;
  logic         out_valid_q, out_valid_d;

  logic [W:0]   m_ext;
  logic [W:0]   a_sub;
  logic [W:0]   a_add;
  logic [W:0]   a_shl;

  assign ctrl = {c7, c6, c5, c4, c3, c2, c1, c0};

  // A is one bit wider than M so the sign of a trial subtraction lands in A[W]
  assign m_ext = {1'b0, m_q};
  assign a_sub = a_q - m_ext;
  assign a_add = a_q + m_ext;
  assign a_shl = {a_q[W-1:0], q_q[W-1]};

  always_comb begin
    m_d = m_q;
    if (ctrl[C_LD_M]) begin
      m_d = inbus;
    end
  end

  always_comb begin
    a_d = a_q;
    if (ctrl[C_LD_Q]) begin
      a_d = '0;
    end else if (ctrl[C_SHIFT]) begin
      a_d = a_shl;
    end else if (ctrl[C_SUB]) begin
      a_d = a_sub;
    end else if (ctrl[C_ADD]) begin
      a_d = a_add;
    end
  end

  // Shift and quotient-bit set may coincide; the set applies after the shift
  always_comb begin
    q_d = q_q;
    if (ctrl[C_LD_Q]) begin
      q_d = inbus;
    end else begin
      if (ctrl[C_SHIFT]) begin
        q_d = {q_q[W-2:0], 1'b0};
      end
      if (ctrl[C_SET_Q0]) begin
        q_d[0] = 1'b1;
      end
    end
  end

  always_comb begin
    outbus_d    = outbus_q;
    out_valid_d = ctrl[C_OUT_Q] | ctrl[C_OUT_R];
    if (ctrl[C_OUT_Q]) begin
      outbus_d = q_q;
    end else if (ctrl[C_OUT_R]) begin
      outbus_d = a_q[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q         <= '0;
      q_q         <= '0;
      a_q         <= '0;
      outbus_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      m_q         <= m_d;
      q_q         <= q_d;
      a_q         <= a_d;
      outbus_q    <= outbus_d;
      out_valid_q <= out_valid_d;
    end
  end

  div_counter #(
    .LIMIT(W)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (ctrl[C_LD_Q]),
    .inc  (ctrl[C_SHIFT]),
    .done (cnt_done)
  );

  assign outbus    = outbus_q;
  assign out_valid = out_valid_q;
  assign q0        = q_q[0];
  assign a7        = a_q[W];

endmodule

// File: tb/tb_div_datapath.sv
// Self-checking bench for div_datapath: directed scenarios plus randomized
// strobe traffic and randomized divisions against a behavioural model.
module tb_div_datapath;

  localparam int W    = 8;
  localparam int QMOD = 256;
  localparam int AMOD = 512;
  localparam int HALF = 128;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] inbus = '0;
  logic [7:0]   ctrl = '0;
  logic [W-1:0] outbus;
  logic         out_valid;
  logic         cnt_done;
  logic         q0;
  logic         a7;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state (plain integers)
  int m_m = 0, m_q = 0, m_a = 0, m_cnt = 0, m_ob = 0;
  int m_ov = 0;

  always #5 clk = ~clk;

  div_datapath #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .inbus     (inbus),
    .c0        (ctrl[0]),
    .c1        (ctrl[1]),
    .c2        (ctrl[2]),
    .c3        (ctrl[3]),
    .c4        (ctrl[4]),
    .c5        (ctrl[5]),
    .c6        (ctrl[6]),
    .c7        (ctrl[7]),
    .outbus    (outbus),
    .out_valid (out_valid),
    .cnt_done  (cnt_done),
    .q0        (q0),
    .a7        (a7)
  );

  task automatic model_step(input logic [7:0] c, input int in, input logic r);
    int a_old, q_old, m_old;
    if (r) begin
      m_m = 0; m_q = 0; m_a = 0; m_cnt = 0; m_ob = 0; m_ov = 0;
    end else begin
      a_old = m_a; q_old = m_q; m_old = m_m;
      if (c[0]) m_m = in;
      if (c[1])      m_a = 0;
      else if (c[2]) m_a = (a_old * 2 + q_old / HALF) % AMOD;
      else if (c[3]) m_a = (a_old - m_old + AMOD) % AMOD;
      else if (c[4]) m_a = (a_old + m_old) % AMOD;
      if (c[1]) m_q = in;
      else begin
        if (c[2]) m_q = (q_old * 2) % QMOD;
        if (c[5]) m_q = m_q | 1;
      end
      if (c[1]) m_cnt = 0;
      else if (c[2] && m_cnt < W) m_cnt = m_cnt + 1;
      m_ov = (c[6] || c[7]) ? 1 : 0;
      if (c[7])      m_ob = q_old;
      else if (c[6]) m_ob = a_old % QMOD;
    end
  endtask

  // One clock with the given strobes; outputs are stable when this returns
  task automatic drive(input logic [7:0] c, input logic [W-1:0] in, input logic r);
    ctrl = c; inbus = in; rst = r;
    @(posedge clk);
    model_step(c, int'(in), r);
    #1;
    ctrl = '0; rst = 1'b0;
  endtask

  task automatic test_reset();
    drive(8'h01, 8'h33, 1'b0);
    drive(8'h02, 8'h44, 1'b0);
    drive(8'h04, 8'h00, 1'b0);
    drive(8'h44, 8'h00, 1'b0);
    drive(8'hFF, 8'hFF, 1'b1);
    n_checks++; if (outbus !== 8'h00) begin n_fail++; $display("FAIL reset_outbus got %h want 00", outbus); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (cnt_done !== 1'b0) begin n_fail++; $display("FAIL reset_cnt_done got %b want 0", cnt_done); end
    n_checks++; if (q0 !== 1'b0) begin n_fail++; $display("FAIL reset_q0 got %b want 0", q0); end
    n_checks++; if (a7 !== 1'b0) begin n_fail++; $display("FAIL reset_a7 got %b want 0", a7); end
    drive(8'h80, 8'h00, 1'b0);
    n_checks++; if (outbus !== 8'h00 || out_valid !== 1'b1) begin n_fail++; $display("FAIL reset_Q got %h/%b want 00/1", outbus, out_valid); end
    // M=0 after reset: subtracting leaves A at zero
    drive(8'h08, 8'h00, 1'b0);
    drive(8'h40, 8'h00, 1'b0);
    n_checks++; if (outbus !== 8'h00 || a7 !== 1'b0) begin n_fail++; $display("FAIL reset_M_A got %h a7=%b want 00 a7=0", outbus, a7); end
  endtask

  task automatic run_iterations(input int n);
    for (int i = 0; i < n; i++) begin
      drive(8'h04, 8'h00, 1'b0);
      n_checks++;
      if (cnt_done !== (i == W - 1)) begin
        n_fail++; $display("FAIL cnt_done_iter%0d got %b want %b", i, cnt_done, (i == W - 1));
      end
      drive(8'h08, 8'h00, 1'b0);
      if (a7) drive(8'h10, 8'h00, 1'b0);
      else    drive(8'h20, 8'h00, 1'b0);
    end
  endtask

  task automatic test_division(input int n, input int d);
    drive(8'h01, W'(d), 1'b0);
    drive(8'h02, W'(n), 1'b0);
    run_iterations(W);
    drive(8'h80, 8'h00, 1'b0);
    n_checks++; if (outbus !== W'(n / d) || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL div_quot %0d/%0d got %0d/%b want %0d/1", n, d, outbus, out_valid, n / d); end
    drive(8'h40, 8'h00, 1'b0);
    n_checks++; if (outbus !== W'(n % d) || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL div_rem %0d/%0d got %0d/%b want %0d/1", n, d, outbus, out_valid, n % d); end
    drive(8'h00, 8'h00, 1'b0);
    n_checks++; if (outbus !== W'(n % d) || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL div_hold got %0d/%b want %0d/0", outbus, out_valid, n % d); end
  endtask

  task automatic test_neg_sub();
    drive(8'h01, 8'd7, 1'b0);
    drive(8'h02, 8'h60, 1'b0);
    for (int i = 0; i < 3; i++) drive(8'h04, 8'h00, 1'b0);
    drive(8'h40, 8'h00, 1'b0);
    n_checks++; if (outbus !== 8'd3 || a7 !== 1'b0) begin n_fail++; $display("FAIL neg_setup got %h a7=%b want 03 a7=0", outbus, a7); end
    drive(8'h08, 8'h00, 1'b0);
    n_checks++; if (a7 !== 1'b1) begin n_fail++; $display("FAIL neg_sub_a7 got %b want 1", a7); end
    drive(8'h40, 8'h00, 1'b0);
    n_checks++; if (outbus !== 8'hFC) begin n_fail++; $display("FAIL neg_sub_A got %h want fc", outbus); end
    drive(8'h10, 8'h00, 1'b0);
    n_checks++; if (a7 !== 1'b0) begin n_fail++; $display("FAIL restore_a7 got %b want 0", a7); end
    drive(8'h40, 8'h00, 1'b0);
    n_checks++; if (outbus !== 8'h03) begin n_fail++; $display("FAIL restore_A got %h want 03", outbus); end
  endtask

  task automatic test_priority();
    drive(8'h02, 8'h81, 1'b0);
    drive(8'h24, 8'h00, 1'b0);
    drive(8'h80, 8'h00, 1'b0);
    n_checks++; if (outbus !== 8'h03) begin n_fail++; $display("FAIL shift_set got %h want 03", outbus); end
    // A=1, cnt=1 now; load must override the shift for Q, A and cnt
    drive(8'h06, 8'h55, 1'b0);
    drive(8'h80, 8'h00, 1'b0);
    n_checks++; if (outbus !== 8'h55) begin n_fail++; $display("FAIL load_over_shift_Q got %h want 55", outbus); end
    drive(8'h40, 8'h00, 1'b0);
    n_checks++; if (outbus !== 8'h00) begin n_fail++; $display("FAIL load_over_shift_A got %h want 00", outbus); end
    for (int i = 0; i < W; i++) begin
      drive(8'h04, 8'h00, 1'b0);
      n_checks++; if (cnt_done !== (i == W - 1)) begin
        n_fail++; $display("FAIL load_clears_cnt shift%0d got %b want %b", i, cnt_done, (i == W - 1)); end
    end
    // Q=00, A=55: Q must win on the bus
    drive(8'hC0, 8'h00, 1'b0);
    n_checks++; if (outbus !== 8'h00 || out_valid !== 1'b1) begin n_fail++; $display("FAIL c7_over_c6 got %h want 00", outbus); end
    drive(8'h40, 8'h00, 1'b0);
    n_checks++; if (outbus !== 8'h55) begin n_fail++; $display("FAIL after_shifts_A got %h want 55", outbus); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      drive(8'h04, 8'h00, 1'b0);
      n_checks++; if (cnt_done !== 1'b1) begin n_fail++; $display("FAIL sat_cnt_done extra%0d got %b want 1", i, cnt_done); end
    end
    drive(8'h02, 8'h00, 1'b0);
    n_checks++; if (cnt_done !== 1'b0) begin n_fail++; $display("FAIL sat_clear got %b want 0", cnt_done); end
    for (int i = 0; i < W; i++) drive(8'h04, 8'h00, 1'b0);
    n_checks++; if (cnt_done !== 1'b1) begin n_fail++; $display("FAIL sat_recount got %b want 1", cnt_done); end
  endtask

  task automatic test_mid_reset();
    drive(8'h01, 8'd7, 1'b0);
    drive(8'h02, 8'd100, 1'b0);
    run_iterations(4);
    drive(8'h00, 8'h00, 1'b1);
    n_checks++; if (outbus !== 8'h00 || out_valid !== 1'b0 || cnt_done !== 1'b0 || q0 !== 1'b0 || a7 !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset got ob=%h ov=%b cd=%b q0=%b a7=%b want all 0", outbus, out_valid, cnt_done, q0, a7); end
    drive(8'h80, 8'h00, 1'b0);
    n_checks++; if (outbus !== 8'h00) begin n_fail++; $display("FAIL mid_reset_Q got %h want 00", outbus); end
    drive(8'h40, 8'h00, 1'b0);
    n_checks++; if (outbus !== 8'h00) begin n_fail++; $display("FAIL mid_reset_A got %h want 00", outbus); end
    test_division(200, 9);
  endtask

  task automatic test_random_strobes();
    logic [7:0] c;
    logic       r;
    for (int i = 0; i < 300; i++) begin
      c = 8'($urandom & $urandom);
      r = ($urandom_range(0, 31) == 0);
      drive(c, W'($urandom), r);
      n_checks++;
      if (outbus !== W'(m_ob) || out_valid !== m_ov[0] || cnt_done !== (m_cnt == W) ||
          q0 !== m_q[0] || a7 !== m_a[W]) begin
        n_fail++;
        $display("FAIL rand_cycle%0d got ob=%h ov=%b cd=%b q0=%b a7=%b want ob=%h ov=%0d cd=%b q0=%0d a7=%0d",
                 i, outbus, out_valid, cnt_done, q0, a7, m_ob, m_ov, (m_cnt == W), m_q % 2, m_a / QMOD);
      end
    end
  endtask

  task automatic test_random_divisions();
    for (int i = 0; i < 10; i++) begin
      test_division(int'($urandom_range(0, 255)), int'($urandom_range(1, 255)));
    end
    test_division(255, 1);
    test_division(0, 255);
    test_division(255, 255);
  endtask

  initial begin
    test_reset();
    test_division(100, 7);
    test_neg_sub();
    test_priority();
    test_saturation();
    test_mid_reset();
    test_random_strobes();
    test_random_divisions();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/div_datapath.md
# div_datapath

Register/arithmetic datapath for the ALU's sequential divider. It sits directly downstream of the divider control FSM: it consumes that FSM's one-hot-style control strobes c0..c7 and returns the status bits cnt_done, q0 and a7 the FSM branches on. It holds divisor M, partial remainder A and dividend/quotient Q, and it iteration-counts. It loads operands from the shared inbus and drives results onto outbus.

## Interface
Parameters:
- W, 8, operand width; A is W+1 bits, M and Q are W bits.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- inbus  in  W  operand input bus.
- c0  in  1  load M from inbus.
- c1  in  1  load Q from inbus; clear A and the counter.
- c2  in  1  shift {A,Q} left by one; Q[0] becomes 0; counter increments.
- c3  in  1  A <= A - {0,M} (W+1-bit, wraps mod 2^(W+1)).
- c4  in  1  A <= A + {0,M} (restore).
- c5  in  1  Q[0] <= 1.
- c6  in  1  request outbus = A[W-1:0] (remainder).
- c7  in  1  request outbus = Q (quotient).
- outbus  out  W  registered result bus.
- out_valid  out  1  outbus holds a value requested in the previous cycle.
- cnt_done  out  1  counter == W.
- q0  out  1  Q[0].
- a7  out  1  sign bit of A, i.e. A[W]; name fixed by the controller interface.

## Operation
- Registers: M[W-1:0], Q[W-1:0], A[W:0], cnt[$clog2(W+1)-1:0].
- M update: c0 only; independent of all other strobes.
- A update priority: c1 (clear) > c2 (shift: A <= {A[W-1:0], Q[W-1]}) > c3 (subtract) > c4 (add). Lower-priority A strobes are ignored in that cycle.
- Q update:
  - c1 loads inbus; c1 overrides c2 and c5.
  - Otherwise c2 shifts, Q <= {Q[W-2:0], 0}.
  - c5 then forces bit 0 to 1. c2+c5 in the same cycle yields {Q[W-2:0],1}.
- Counter:
  - Cleared by c1.
  - Incremented by c2 (when c1 low).
  - Saturates at W and never wraps; further c2 leaves it at W.
- Status outputs are continuous functions of the registers, valid the cycle after the strobe that changed them.
- Outbus: c7 has priority over c6.
  - On the next edge outbus <= (c7 ? Q : A[W-1:0]) and out_valid <= 1.
  - With neither c6 nor c7, outbus holds its last value and out_valid <= 0.
- Reference restoring sequence per iteration, driven by the controller: c2; c3; then c4 if a7 else c5; repeat until cnt_done.

## Timing
- Reset, on a clock edge with rst high, overriding all strobes:
  - M, Q, A, cnt = 0.
  - outbus = 0, out_valid = 0.
  - cnt_done = 0; q0 = 0; a7 = 0.
- Reset mid-division discards all state. The next operation needs fresh c0/c1 loads.
- Every strobe takes effect at the edge where it is sampled high. Latency is 1 cycle from strobe to register/status.
- outbus/out_valid appear 1 cycle after c6/c7.
- No back-pressure. Strobes are single-cycle pulses or levels; a held strobe repeats its action every cycle.
- cnt_done rises in the cycle after the W-th c2.
- Combinational path: subtract/add (W+1 bits) and shift mux into A. No path from inbus to outbus within one cycle.

## Structure
- Package div_pkg holds:
  - DIV_W default;
  - localparams for control-strobe indices C_LD_M..C_OUT_Q (0..7);
  - the counter width function.
- The control FSM shares this package.
- One sub-module: div_counter. It provides a saturating up-counter with sync clear, increment and a done compare against a parameter limit.
- The adder/subtractor stays inline.

## Test plan
- Reset check: assert rst with all strobes high → M=Q=A=0, cnt_done=0, out_valid=0 on the next cycle.
- Full division, W=8:
  - Load M=7 (c0) and Q=100 (c1).
  - Run 8 iterations of c2; c3; c4-if-a7-else-c5.
  - Expect cnt_done=1 after the 8th c2.
  - c7 → outbus=14 (0x0E); c6 → outbus=2; out_valid=1 each time.
- Negative subtraction: A=3, M=7, pulse c3 → A=0x1FC, a7=1. Pulse c4 → A=3, a7=0.
- Strobe priority:
  - c2+c5 with Q=0x81 → Q=0x03.
  - c1+c2 with inbus=0x55 → Q=0x55, A=0, cnt=0.
  - c6+c7 → outbus=Q.
- Counter saturation: with cnt_done high, issue 3 more c2 pulses → cnt stays 8, cnt_done stays 1.
- Mid-operation reset: assert rst after 4 iterations of the 100/7 division → all registers 0 next cycle. A new 200/9 load-and-run then yields Q=22, R=2.
